// File: rtl/fetch_sequencer.sv
// Fetch-side PC controller: issues imem reads, holds one fetched word for decode,
// and applies branch/trap redirects, squashing any fetch already in flight.
module fetch_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] PCNext,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_WAIT,
        S_KILL
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] addr_q;
    logic            redir;
    logic [XLEN-1:0] redir_pc;
    logic            can_issue;
    logic            fill;
    logic [XLEN-1:0] pc_inc;

    assign redir     = (trap_valid || redirect_valid) && (state != S_BOOT);
    assign redir_pc  = trap_valid ? TRAP_VECTOR : {redirect_pc[XLEN-1:2], 2'b00};
    assign can_issue = !instr_valid || instr_ready;
    assign pc_inc    = pc + XLEN'(4);

    // Request and PCNext are combinational: they react to imem_ready/instr_ready
    // in the same cycle so a zero-wait memory sustains one fetch per cycle.
    always_comb begin
        PCNext     = pc;
        imem_req   = 1'b0;
        imem_addr  = pc;
        fill       = 1'b0;
        state_next = state;
        case (state)
            S_BOOT: begin
                PCNext     = RESET_VECTOR;
                state_next = S_FETCH;
            end
            S_FETCH: begin
                if (redir) begin
                    PCNext = redir_pc;
                end else if (can_issue) begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        fill   = 1'b1;
                        PCNext = pc_inc;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                imem_req  = 1'b1;
                imem_addr = addr_q;
                if (redir) begin
                    PCNext     = redir_pc;
                    state_next = imem_ready ? S_FETCH : S_KILL;
                end else if (imem_ready) begin
                    fill       = 1'b1;
                    PCNext     = pc_inc;
                    state_next = S_FETCH;
                end
            end
            S_KILL: begin
                // Stale request must complete before a new one; its data is dropped.
                imem_req  = 1'b1;
                imem_addr = addr_q;
                if (redir) begin
                    PCNext = redir_pc;
                end
                if (imem_ready) begin
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_BOOT;
            addr_q      <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            state <= state_next;
            if (state == S_FETCH && imem_req && !imem_ready) begin
                addr_q <= pc;
            end
            if (redir) begin
                instr_valid <= 1'b0;
            end else if (fill) begin
                instr_valid <= 1'b1;
                instr       <= imem_rdata;
                instr_pc    <= imem_addr;
            end else if (instr_ready) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; the bench owns the PC register (pc <= PCNext).
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc = '0;
    logic [31:0] PCNext;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    fetch_sequencer #(
        .XLEN        (32),
        .RESET_VECTOR(32'h0000_1000),
        .TRAP_VECTOR (32'h0000_0100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .PCNext        (PCNext),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .trap_valid    (trap_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pc <= PCNext;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        imem_ready     = 1'b0;
        imem_rdata     = '0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        trap_valid     = 1'b0;

        // 1: reset for 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick;
            #1;
            check("rst_pcnext", PCNext, 32'h1000);
            check("rst_req", imem_req, 0);
            check("rst_valid", instr_valid, 0);
            check("rst_instr", instr, 0);
            check("rst_instr_pc", instr_pc, 0);
        end
        reset = 1'b0;
        #1;
        check("boot_req", imem_req, 0);
        check("boot_pcnext", PCNext, 32'h1000);
        tick;

        // 2: zero-wait streaming
        imem_ready  = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_rdata = 32'hA000_0000 + 32'(i);
            #1;
            check("stream_req", imem_req, 1);
            check("stream_addr", imem_addr, 32'h1000 + 32'(4 * i));
            check("stream_pcnext", PCNext, 32'h1004 + 32'(4 * i));
            tick;
            check("stream_valid", instr_valid, 1);
            check("stream_instr_pc", instr_pc, 32'h1000 + 32'(4 * i));
            check("stream_instr", instr, 32'hA000_0000 + 32'(i));
        end

        // 3: decode back-pressure
        instr_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("bp_req", imem_req, 0);
            check("bp_pcnext", PCNext, 32'h100C);
            tick;
            check("bp_valid", instr_valid, 1);
            check("bp_instr_pc", instr_pc, 32'h1008);
            check("bp_instr", instr, 32'hA000_0002);
        end
        instr_ready = 1'b1;
        imem_rdata  = 32'hB000_0000;
        #1;
        check("bp_rel_req", imem_req, 1);
        check("bp_rel_addr", imem_addr, 32'h100C);
        check("bp_rel_pcnext", PCNext, 32'h1010);
        tick;
        check("bp_rel_instr_pc", instr_pc, 32'h100C);
        check("bp_rel_instr", instr, 32'hB000_0000);

        // 4: wait states at 0x2000 (redirect there first)
        imem_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2000;
        #1;
        check("redir_req", imem_req, 0);
        check("redir_pcnext", PCNext, 32'h2000);
        tick;
        redirect_valid = 1'b0;
        check("redir_flush", instr_valid, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("wait_req", imem_req, 1);
            check("wait_addr", imem_addr, 32'h2000);
            check("wait_pcnext", PCNext, 32'h2000);
            tick;
        end
        imem_ready = 1'b1;
        imem_rdata = 32'hC000_0000;
        #1;
        check("wait_rdy_addr", imem_addr, 32'h2000);
        check("wait_rdy_pcnext", PCNext, 32'h2004);
        tick;
        check("wait_valid", instr_valid, 1);
        check("wait_instr_pc", instr_pc, 32'h2000);
        check("wait_instr", instr, 32'hC000_0000);

        // 5: redirect while waiting at 0x2000 -> KILL
        imem_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2000;
        tick;
        redirect_valid = 1'b0;
        tick;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3002;
        #1;
        check("kill_redir_pcnext", PCNext, 32'h3000);
        check("kill_redir_addr", imem_addr, 32'h2000);
        tick;
        redirect_valid = 1'b0;
        #1;
        check("kill_req", imem_req, 1);
        check("kill_addr", imem_addr, 32'h2000);
        check("kill_pcnext", PCNext, 32'h3000);
        check("kill_valid", instr_valid, 0);
        tick;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("kill_rdy_addr", imem_addr, 32'h2000);
        check("kill_rdy_pcnext", PCNext, 32'h3000);
        tick;
        check("kill_stale_valid", instr_valid, 0);
        imem_rdata = 32'hE000_0000;
        #1;
        check("post_kill_req", imem_req, 1);
        check("post_kill_addr", imem_addr, 32'h3000);
        check("post_kill_pcnext", PCNext, 32'h3004);
        tick;
        check("post_kill_instr_pc", instr_pc, 32'h3000);
        check("post_kill_instr", instr, 32'hE000_0000);

        // 6: trap priority and PC wrap
        trap_valid     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4000;
        #1;
        check("trap_pcnext", PCNext, 32'h0100);
        check("trap_req", imem_req, 0);
        tick;
        trap_valid  = 1'b0;
        check("trap_flush", instr_valid, 0);
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        check("wrap_redir_pcnext", PCNext, 32'hFFFF_FFFC);
        tick;
        redirect_valid = 1'b0;
        imem_rdata     = 32'hF000_0000;
        #1;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap_pcnext", PCNext, 32'h0000_0000);
        tick;
        check("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        check("wrap_next_addr", imem_addr, 32'h0000_0000);

        // reset with a fetch outstanding
        imem_ready = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        check("midrst_req", imem_req, 0);
        check("midrst_valid", instr_valid, 0);
        check("midrst_pcnext", PCNext, 32'h1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
